// File: rtl/spi_controller_if.sv
// Purpose : command port plus SPI pins of the SPI mode-0 controller, bundled as one interface.
// Latency : n/a (wires only).
// Backpressure: start is honoured only while busy=0; there is no other flow control.
// Ports   : start/rw/addr/wdata/abort (command in), busy/done (status out),
//           nCS/SCLK/COPI (SPI pins out). master = controller side, slave = host/bench side.
interface spi_controller_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       abort;
  logic       busy;
  logic       done;
  logic       nCS;
  logic       SCLK;
  logic       COPI;

  modport master (
    input  start, rw, addr, wdata, abort,
    output busy, done, nCS, SCLK, COPI
  );

  modport slave (
    output start, rw, addr, wdata, abort,
    input  busy, done, nCS, SCLK, COPI
  );
endinterface

// File: rtl/spi_controller.sv
// Purpose : SPI mode-0 master; shifts one 16-bit frame {rw, addr[6:0], wdata[7:0]} MSB-first.
// Latency : nCS falls 1 cycle after accept; done 1+CS_SETUP+32*CLK_DIV+CS_HOLD after accept.
// Backpressure: start ignored while busy; abort ends the frame early and still runs the gap.
// Ports   : clk, rst_n (async, active low), bus (spi_controller_if.master: command + SPI pins).
//           Every output is a flop; nothing combinational from inputs to outputs.
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

  // Phase counters run 0..N-1, so each phase ends on the edge where cnt hits N-1.
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  // Holds {addr, wdata}; rw goes straight to COPI at accept, so bit 15 is never stored.
  logic [14:0] shift, shift_nxt;
  logic        ncs, ncs_nxt;
  logic        sclk, sclk_nxt;
  logic        copi, copi_nxt;
  logic        busy, busy_nxt;
  logic        done, done_nxt;
  logic        in_frame;

  // abort is only meaningful while nCS is low; in GAP/IDLE it has no effect.
  assign in_frame = (state == SETUP) || (state == LOW) || (state == HIGH) || (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      ncs     <= 1'b1;
      sclk    <= 1'b0;
      copi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
      ncs     <= ncs_nxt;
      sclk    <= sclk_nxt;
      copi    <= copi_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 8'd1;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    ncs_nxt     = ncs;
    sclk_nxt    = sclk;
    copi_nxt    = copi;
    busy_nxt    = busy;
    done_nxt    = 1'b0;

    if (bus.abort && in_frame) begin
      // Drop the frame mid-flight; the receiver sees fewer than 16 rises and discards it.
      state_nxt   = GAP;
      cnt_nxt     = '0;
      bit_cnt_nxt = '0;
      ncs_nxt     = 1'b1;
      sclk_nxt    = 1'b0;
      copi_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (bus.start) begin
            shift_nxt   = {bus.addr, bus.wdata};
            copi_nxt    = bus.rw;
            bit_cnt_nxt = '0;
            ncs_nxt     = 1'b0;
            busy_nxt    = 1'b1;
            state_nxt   = SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt_nxt   = '0;
            state_nxt = LOW;
          end
        end
        LOW: begin
          if (cnt == DIV_LAST) begin
            cnt_nxt   = '0;
            sclk_nxt  = 1'b1;
            state_nxt = HIGH;
          end
        end
        HIGH: begin
          if (cnt == DIV_LAST) begin
            cnt_nxt     = '0;
            sclk_nxt    = 1'b0;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              copi_nxt  = 1'b0;
              state_nxt = HOLD;
            end else begin
              // Data changes on the falling edge, a full LOW phase before the next rise.
              copi_nxt  = shift[14];
              shift_nxt = {shift[13:0], 1'b0};
              state_nxt = LOW;
            end
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt_nxt   = '0;
            ncs_nxt   = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = GAP;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt_nxt   = '0;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign bus.nCS  = ncs;
  assign bus.SCLK = sclk;
  assign bus.COPI = copi;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: tb/tb_spi_controller.sv
// Purpose : directed bench for spi_controller with a behavioural SPI register receiver model.
// Latency : n/a.
// Backpressure: n/a; two DUTs (default and minimum timing) share clk/rst_n, sel picks one.
module tb_spi_controller;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 4;
  localparam int CS_GAP   = 4;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       abort;

  spi_controller_if ifa ();
  spi_controller_if ifb ();

  spi_controller #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP))
    u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  spi_controller #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(2), .CS_GAP(2))
    u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  assign ifa.start = start & ~sel;
  assign ifa.abort = abort & ~sel;
  assign ifa.rw    = rw;
  assign ifa.addr  = addr;
  assign ifa.wdata = wdata;
  assign ifb.start = start & sel;
  assign ifb.abort = abort & sel;
  assign ifb.rw    = rw;
  assign ifb.addr  = addr;
  assign ifb.wdata = wdata;

  wire m_ncs  = sel ? ifb.nCS  : ifa.nCS;
  wire m_sclk = sel ? ifb.SCLK : ifa.SCLK;
  wire m_copi = sel ? ifb.COPI : ifa.COPI;
  wire m_busy = sel ? ifb.busy : ifa.busy;
  wire m_done = sel ? ifb.done : ifa.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Edge counter; a sample at negedge with value e reflects spec time (e - accept_edge + 1).
  int e = 0;
  always @(posedge clk) e <= e + 1;

  // Receiver / timing monitor, sampled on negedge.
  logic        p_ncs = 1'b1, p_sclk = 1'b0, p_copi = 1'b0, p_busy = 1'b0;
  logic [15:0] rx_sh = '0, rx_last = '0;
  logic [7:0]  regs [128];
  int rx_cnt = 0, rx_frames = 0, bad_sclk = 0, done_cnt = 0;
  int acc_e = 0, done_rel = 0, busy_fall_rel = 0, first_rise_rel = 0;
  int ncs_rise_e = 0, gap_e = 0, stab = 0, min_stab = 999;

  initial for (int i = 0; i < 128; i++) regs[i] = 8'h00;

  always @(negedge clk) begin
    if (m_ncs && !p_ncs) begin
      ncs_rise_e = e;
      if (rx_cnt == 16) begin
        rx_last = rx_sh;
        rx_frames++;
        if (rx_sh[15]) regs[rx_sh[14:8]] = rx_sh[7:0];
      end
    end
    if (!m_ncs && p_ncs) begin
      rx_cnt = 0;
      rx_sh  = '0;
      gap_e  = e - ncs_rise_e;
    end
    if (m_copi != p_copi) stab = 0;
    else stab++;
    if (m_sclk && !p_sclk) begin
      if (m_ncs) bad_sclk++;
      else begin
        if (rx_cnt == 0) first_rise_rel = e - acc_e + 1;
        if (stab < min_stab) min_stab = stab;
        rx_sh = {rx_sh[14:0], m_copi};
        rx_cnt++;
      end
    end
    if (m_busy && !p_busy) acc_e = e;
    if (!m_busy && p_busy) busy_fall_rel = e - acc_e + 1;
    if (m_done) begin
      done_cnt++;
      done_rel = e - acc_e + 1;
    end
    p_ncs  = m_ncs;
    p_sclk = m_sclk;
    p_copi = m_copi;
    p_busy = m_busy;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (m_busy && n < 1000) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, m_busy, 1'b0);
  endtask

  task automatic send(input logic r, input logic [6:0] a, input logic [7:0] d, input string tag);
    int n = 0;
    tick();
    start = 1'b1; rw = r; addr = a; wdata = d;
    do begin
      tick();
      n++;
    end while (!m_busy && n < 20);
    start = 1'b0;
    check({tag, "_accept"}, m_busy, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_done, base_frames, n;
    rst_n = 1'b0; sel = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; abort = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_ncs",  m_ncs,  1'b1);
    check("rst_sclk", m_sclk, 1'b0);
    check("rst_copi", m_copi, 1'b0);
    check("rst_busy", m_busy, 1'b0);
    check("rst_done", m_done, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: single write frame, default timing
    base_done = done_cnt; base_frames = rx_frames;
    send(1'b1, 7'h04, 8'hA5, "t1");
    wait_idle("t1");
    check("t1_frame",      rx_last, 16'h84A5);
    check("t1_rises",      rx_cnt, 16);
    check("t1_frames",     rx_frames - base_frames, 1);
    check("t1_done_cnt",   done_cnt - base_done, 1);
    check("t1_done_rel",   done_rel, 135);
    check("t1_busy_low",   busy_fall_rel, 139);
    check("t1_first_rise", first_rise_rel, 7);
    check("t1_copi_setup", (min_stab >= CLK_DIV) ? 1 : 0, 1);

    // 2: register writes then a read frame that must not modify anything
    send(1'b1, 7'h00, 8'h11, "t2a"); wait_idle("t2a");
    send(1'b1, 7'h01, 8'h22, "t2b"); wait_idle("t2b");
    send(1'b1, 7'h02, 8'h33, "t2c"); wait_idle("t2c");
    send(1'b1, 7'h03, 8'h44, "t2d"); wait_idle("t2d");
    send(1'b1, 7'h04, 8'h55, "t2e"); wait_idle("t2e");
    send(1'b0, 7'h02, 8'hFF, "t2r"); wait_idle("t2r");
    check("t2_reg0", regs[0], 8'h11);
    check("t2_reg1", regs[1], 8'h22);
    check("t2_reg2", regs[2], 8'h33);
    check("t2_reg3", regs[3], 8'h44);
    check("t2_reg4", regs[4], 8'h55);
    check("t2_rd_frame", rx_last, 16'h02FF);

    // 3: start held high -> back-to-back frames; gap = CS_GAP cycles plus the IDLE accept cycle
    base_done = done_cnt; base_frames = rx_frames;
    tick();
    start = 1'b1; rw = 1'b1; addr = 7'h10; wdata = 8'h3C;
    n = 0;
    while (done_cnt < base_done + 2 && n < 1000) begin
      tick();
      n++;
    end
    start = 1'b0;
    wait_idle("t3");
    check("t3_done_cnt", done_cnt - base_done, 2);
    check("t3_frames",   rx_frames - base_frames, 2);
    check("t3_gap",      gap_e, CS_GAP + 1);
    check("t3_frame",    rx_last, 16'h903C);

    // 3b: a start pulse mid-frame is ignored
    base_done = done_cnt; base_frames = rx_frames;
    send(1'b1, 7'h06, 8'h5A, "t3b");
    repeat (20) tick();
    start = 1'b1; rw = 1'b1; addr = 7'h05; wdata = 8'h66;
    tick();
    start = 1'b0;
    wait_idle("t3b");
    repeat (8) tick();
    check("t3b_done_cnt", done_cnt - base_done, 1);
    check("t3b_frame",    rx_last, 16'h865A);
    check("t3b_reg5",     regs[5], 8'h00);

    // 4: abort after the 5th SCLK rise
    base_done = done_cnt; base_frames = rx_frames;
    send(1'b1, 7'h07, 8'hC3, "t4");
    n = 0;
    while (rx_cnt < 5 && n < 200) begin
      tick();
      n++;
    end
    check("t4_rise5", rx_cnt, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_ncs",  m_ncs,  1'b1);
    check("t4_sclk", m_sclk, 1'b0);
    check("t4_copi", m_copi, 1'b0);
    check("t4_busy", m_busy, 1'b1);
    n = 0;
    while (m_busy && n < 50) begin
      tick();
      n++;
    end
    check("t4_gap_len",  n, CS_GAP);
    check("t4_no_done",  done_cnt - base_done, 0);
    check("t4_no_frame", rx_frames - base_frames, 0);
    check("t4_reg7",     regs[7], 8'h00);
    send(1'b1, 7'h07, 8'hC3, "t4n");
    wait_idle("t4n");
    check("t4n_frame", rx_last, 16'h87C3);
    check("t4n_reg7",  regs[7], 8'hC3);

    // 5: async reset while SCLK is high for bit 9
    base_done = done_cnt; base_frames = rx_frames;
    send(1'b1, 7'h08, 8'h99, "t5");
    n = 0;
    while (rx_cnt < 10 && n < 300) begin
      tick();
      n++;
    end
    check("t5_sclk_hi", m_sclk, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_ncs",  m_ncs,  1'b1);
    check("t5_sclk", m_sclk, 1'b0);
    check("t5_busy", m_busy, 1'b0);
    check("t5_done", m_done, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("t5_no_done",  done_cnt - base_done, 0);
    check("t5_no_frame", rx_frames - base_frames, 0);
    check("t5_reg8",     regs[8], 8'h00);
    send(1'b1, 7'h08, 8'h99, "t5n");
    wait_idle("t5n");
    check("t5n_frame", rx_last, 16'h8899);

    // 6: minimum timing DUT
    repeat (4) tick();
    sel = 1'b1;
    repeat (2) tick();
    regs[4] = 8'h00;
    base_done = done_cnt;
    send(1'b1, 7'h04, 8'hA5, "t6");
    wait_idle("t6");
    check("t6_frame",      rx_last, 16'h84A5);
    check("t6_reg4",       regs[4], 8'hA5);
    check("t6_done_rel",   done_rel, 68);
    check("t6_done_cnt",   done_cnt - base_done, 1);
    check("t6_busy_low",   busy_fall_rel, 70);
    check("t6_first_rise", first_rise_rel, 4);
    check("t6_copi_setup", (min_stab >= 2) ? 1 : 0, 1);

    check("sclk_while_ncs_high", bad_sclk, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
